// File: rtl/riscv_pkg.sv
// Shared RV32 constants used by the front end: NOP encoding, major opcodes
// and the fetch-state encoding.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC and issues one word read at a time into a single-entry buffer.
// Latency is memory latency + 1; the next fetch waits for the buffer to empty or drain.
module if_stage
  import riscv_pkg::*;
#(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [31:0]      id_instr,
  output logic [XLEN-1:0]  id_pc,
  output logic [6:0]       id_op
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] redirect_tgt;
  logic            drain;
  logic            req;

  assign redirect_tgt = redirect_pc & ALIGN_MASK;
  assign drain        = id_valid && id_ready;

  // A fetch only starts when its result is guaranteed a free buffer slot on arrival.
  assign req = rst_n && (state == S_REQ) && !redirect_valid && (!id_valid || id_ready);

  assign imem_req  = req;
  assign imem_addr = pc;
  assign id_op     = id_instr[6:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_tgt;
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      case (state)
        S_REQ:   state <= S_REQ;
        S_WAIT,
        S_DROP:  state <= imem_rvalid ? S_REQ : S_DROP;
        default: state <= S_REQ;
      endcase
    end else begin
      if (drain) begin
        id_valid <= 1'b0;
        id_instr <= NOP_INSTR;
      end
      case (state)
        S_REQ: begin
          if (req) state <= S_WAIT;
        end
        S_WAIT: begin
          // Capture is placed after the drain so a same-edge drain+capture keeps the new word.
          if (imem_rvalid) begin
            id_instr <= imem_rdata;
            id_pc    <= pc;
            id_valid <= 1'b1;
            pc       <= pc + PC_STEP;
            state    <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rvalid) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level fetch model.
module tb_if_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_op;

  always #5 clk = ~clk;

  if_stage #(
    .XLEN(32),
    .RESET_PC(32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .id_valid(id_valid),
    .id_ready(id_ready),
    .id_instr(id_instr),
    .id_pc(id_pc),
    .id_op(id_op)
  );

  localparam logic [31:0] NOP = 32'h0000_0013;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h0000_0000: memword = 32'h0050_0093;
      32'h0000_0004: memword = 32'h0020_8133;
      default:       memword = (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  // memory responder
  logic        mpend = 1'b0;
  int          mcnt = 0;
  logic [31:0] maddr = '0;
  int          mem_lat = 1;
  bit          rnd_lat = 1'b0;

  // reference model: architectural PC, buffer contents, outstanding fetches
  typedef struct {
    logic [31:0] addr;
    bit          wanted;
  } fetch_t;

  logic        m_valid = 1'b0;
  logic [31:0] m_instr = NOP;
  logic [31:0] m_idpc = '0;
  logic [31:0] m_pc = '0;
  fetch_t      q[$];

  // snapshot of DUT outputs taken mid-cycle by step()
  logic [31:0] s_req, s_addr, s_valid, s_instr, s_pc, s_op;

  task automatic model_reset();
    m_valid = 1'b0;
    m_instr = NOP;
    m_idpc  = '0;
    m_pc    = 32'h0000_0000;
    q.delete();
    mpend       = 1'b0;
    imem_rvalid = 1'b0;
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
    logic   exp_req;
    fetch_t f;
    id_ready       = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rvalid    = 1'b0;
    imem_rdata     = $urandom;
    if (mpend) begin
      mcnt--;
      if (mcnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memword(maddr);
        mpend       = 1'b0;
      end
    end
    @(negedge clk);
    s_req   = {31'b0, imem_req};
    s_addr  = imem_addr;
    s_valid = {31'b0, id_valid};
    s_instr = id_instr;
    s_pc    = id_pc;
    s_op    = {25'b0, id_op};

    exp_req = (q.size() == 0) && !redir && (!m_valid || rdy);
    chk("imem_req", s_req, {31'b0, exp_req});
    if (exp_req && imem_req) chk("imem_addr", s_addr, m_pc);
    chk("id_valid", s_valid, {31'b0, m_valid});
    chk("id_instr", s_instr, m_instr);
    chk("id_pc", s_pc, m_idpc);
    chk("id_op", s_op, {25'b0, m_instr[6:0]});
    if (imem_rvalid) chk("outstanding", 32'(q.size()), 32'd1);

    if (redir) begin
      m_valid = 1'b0;
      m_instr = NOP;
      m_pc    = rpc & ~32'h3;
      if (imem_rvalid && q.size() > 0) f = q.pop_front();
      foreach (q[i]) q[i].wanted = 1'b0;
    end else begin
      if (m_valid && rdy) begin
        m_valid = 1'b0;
        m_instr = NOP;
      end
      if (exp_req) q.push_back('{addr: m_pc, wanted: 1'b1});
      if (imem_rvalid && q.size() > 0) begin
        f = q.pop_front();
        if (f.wanted) begin
          m_valid = 1'b1;
          m_instr = imem_rdata;
          m_idpc  = f.addr;
          m_pc    = f.addr + 32'd4;
        end
      end
    end

    if (imem_req) begin
      mpend = 1'b1;
      maddr = imem_addr;
      mcnt  = rnd_lat ? int'($urandom_range(1, 3)) : mem_lat;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag, input int max);
    bit got = 1'b0;
    for (int i = 0; i < max; i++) begin
      step(1'b1, 1'b0, 32'h0);
      if (s_req[0]) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_timeout"}, {31'b0, got}, 32'd1);
  endtask

  // Asserts reset mid-cycle, checks outputs settle without a clock edge, releases at posedge+1.
  task automatic do_reset();
    @(posedge clk);
    #3;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    rst_n          = 1'b0;
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, NOP);
    chk("rst_pc", id_pc, 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic        rdy, redir;
    logic [31:0] rpc;

    // back-to-back fetches with 1-cycle memory
    do_reset();
    mem_lat = 1;
    step(1'b1, 1'b0, 32'h0);
    chk("t1_req0", s_req, 32'd1);
    chk("t1_addr0", s_addr, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("t1_gap0", s_valid, 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("t1_valid0", s_valid, 32'd1);
    chk("t1_instr0", s_instr, 32'h0050_0093);
    chk("t1_pc0", s_pc, 32'h0);
    chk("t1_op0", s_op, {25'b0, OP_I});
    chk("t1_addr4", s_addr, 32'h4);
    step(1'b1, 1'b0, 32'h0);
    chk("t1_gap1", s_valid, 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("t1_instr1", s_instr, 32'h0020_8133);
    chk("t1_op1", s_op, {25'b0, OP_R});
    chk("t1_pc1", s_pc, 32'h4);

    // decode stall freezes the buffer and suppresses fetch
    do_reset();
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 32'h0);
      chk("t2_frozen_valid", s_valid, 32'd1);
      chk("t2_frozen_instr", s_instr, 32'h0050_0093);
      chk("t2_frozen_pc", s_pc, 32'h0);
      chk("t2_no_req", s_req, 32'd0);
    end
    mem_lat = 3;
    step(1'b1, 1'b0, 32'h0);
    chk("t2_req_on_ready", s_req, 32'd1);
    chk("t2_addr4", s_addr, 32'h4);

    // redirect while waiting; late response is dropped
    step(1'b1, 1'b1, 32'h0000_0103);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("t3_dropped", s_valid, 32'd0);
    mem_lat = 1;
    wait_req("t3_req", 10);
    chk("t3_addr", s_addr, 32'h0000_0100);

    // redirect coincident with response
    step(1'b1, 1'b1, 32'h0000_0200);
    step(1'b1, 1'b0, 32'h0);
    chk("t4_valid", s_valid, 32'd0);
    chk("t4_req", s_req, 32'd1);
    chk("t4_addr", s_addr, 32'h0000_0200);

    // PC wrap at the top of the address space
    step(1'b1, 1'b1, 32'hFFFF_FFFF);
    wait_req("t5_req_a", 10);
    chk("t5_addr_top", s_addr, 32'hFFFF_FFFC);
    wait_req("t5_req_b", 10);
    chk("t5_addr_wrap", s_addr, 32'h0000_0000);
    chk("t5_pc_top", s_pc, 32'hFFFF_FFFC);

    // asynchronous reset with a stalled, valid buffer
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("t6_pre_valid", s_valid, 32'd1);
    do_reset();
    step(1'b1, 1'b0, 32'h0);
    chk("t6_req", s_req, 32'd1);
    chk("t6_addr", s_addr, 32'h0);

    // randomized traffic
    rnd_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                           rpc = $urandom & 32'h0000_0FFF;
      step(rdy, redir, rpc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
